morse_sequencer: RTL and testbench

- Controller that sequences the 14-bit Morse pattern shifter for a whole message, not a single key press.
- Accepts 3-bit letter codes (000=s … 111=z) through a valid/ready interface into a small FIFO.
- Per letter: loads the pattern, shifts it out LSB-first at the dot rate, then inserts an inter-letter gap.
- Contains its own tick divider and drives the board LED; sits between switch/key capture logic and LEDR.

---
 rtl/morse_pkg.sv | 29 ++
 rtl/morse_letter_fifo.sv | 80 ++++++++
 rtl/morse_sequencer.sv | 162 ++++++++++++++++
 tb/tb_morse_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// ============================================================================
// Module      : morse_pkg
// Description : Shared widths, letter pattern table and FSM state type for the
//               Morse message sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package morse_pkg;

    localparam int PATTERN_W = 14;
    localparam int LETTER_W  = 3;

    // Indexed by letter code 0..7 (s..z); bit0 is the first unit on the LED.
    localparam logic [PATTERN_W-1:0] c_patterns [0:7] = '{
        14'h0015, 14'h0007, 14'h0075, 14'h01D5,
        14'h01DD, 14'h0757, 14'h1DD7, 14'h0577
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/morse_letter_fifo.sv
// ============================================================================
// Module      : morse_letter_fifo
// Description : DEPTH-entry synchronous FIFO of letter codes with occupancy
//               count and a synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_letter_fifo
    import morse_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = LETTER_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign full     = (r_count == c_full_cnt);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/morse_sequencer.sv
// ============================================================================
// Module      : morse_sequencer
// Description : Plays a queue of Morse letters on the LED: load pattern, shift
//               it out LSB-first at the unit rate, then a forced-low gap.
//               Optional synchronous abort input under MORSE_SEQ_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_sequencer
    import morse_pkg::*;
#(
    parameter int TICK_DIV  = 25000000,
    parameter int GAP_TICKS = 3,
    parameter int DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [LETTER_W-1:0]     letter_in,
    input  logic                    letter_valid,
`ifdef MORSE_SEQ_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    letter_ready,
    output logic                    flash,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_gap_w  = $clog2(GAP_TICKS + 1);
    localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_gap_w-1:0]  c_gap_load = c_gap_w'(GAP_TICKS);

    state_t                r_state;
    logic [PATTERN_W-1:0]  r_shift;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic [c_gap_w-1:0]    r_gap_cnt;
    logic                  r_flash;
    logic                  r_busy;

    logic                  w_abort;
    logic                  w_tick;
    logic [PATTERN_W-1:0]  w_shift_next;
    logic [PATTERN_W-1:0]  w_pattern;
    logic [LETTER_W-1:0]   w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;

`ifdef MORSE_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_tick       = (r_tick_cnt == '0);
    assign w_shift_next = r_shift >> 1;
    assign w_pattern    = c_patterns[w_head];
    assign w_push       = letter_valid && !w_fifo_full && !w_abort;
    assign w_pop        = (r_state == LOAD);

    assign letter_ready = !w_fifo_full;
    assign flash        = r_flash;
    assign busy         = r_busy;

    morse_letter_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LETTER_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (w_abort),
        .push      (w_push),
        .push_data (letter_in),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fifo_count)
    );

    // flash and busy are registered from the next state so they line up
    // exactly with the state the FSM is in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_tick_cnt <= '0;
            r_gap_cnt  <= '0;
            r_flash    <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_abort) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_tick_cnt <= '0;
            r_gap_cnt  <= '0;
            r_flash    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_flash <= 1'b0;
                    if (!w_fifo_empty) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    r_shift    <= w_pattern;
                    r_tick_cnt <= c_tick_max;
                    r_flash    <= w_pattern[0];
                    r_busy     <= 1'b1;
                    r_state    <= PLAY;
                end
                PLAY: begin
                    if (w_tick) begin
                        r_tick_cnt <= c_tick_max;
                        r_shift    <= w_shift_next;
                        if (w_shift_next == '0) begin
                            r_state   <= GAP;
                            r_gap_cnt <= c_gap_load;
                            r_flash   <= 1'b0;
                        end else begin
                            r_flash   <= w_shift_next[0];
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt - c_tick_w'(1);
                    end
                end
                GAP: begin
                    r_flash <= 1'b0;
                    if (w_tick) begin
                        r_tick_cnt <= c_tick_max;
                        r_gap_cnt  <= r_gap_cnt - c_gap_w'(1);
                        if (r_gap_cnt == c_gap_w'(1)) begin
                            if (!w_fifo_empty) begin
                                r_state <= LOAD;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt - c_tick_w'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_flash <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_morse_sequencer.sv
// ============================================================================
// Module      : tb_morse_sequencer
// Description : Self-checking bench; a per-letter waveform queue model
//               predicts flash/busy/ready/count every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_sequencer;

    localparam int TICK_DIV  = 2;
    localparam int GAP_TICKS = 3;
    localparam int DEPTH     = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] letter_in = 3'd0;
    logic       letter_valid = 1'b0;
`ifdef MORSE_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       letter_ready;
    logic       flash;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model: accepted letters, plus the remaining per-cycle flash values of
    // the letter segment in progress (LOAD cycle, pattern units, gap).
    logic [2:0]  m_q [$];
    logic        m_wave [$];
    bit          m_pop_pending;
    logic        m_flash;
    logic        m_busy;
    logic [13:0] ref_pat [8] = '{14'h0015, 14'h0007, 14'h0075, 14'h01D5,
                                 14'h01DD, 14'h0757, 14'h1DD7, 14'h0577};

    always #5 clk = ~clk;

    morse_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .GAP_TICKS (GAP_TICKS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .letter_in    (letter_in),
        .letter_valid (letter_valid),
`ifdef MORSE_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .letter_ready (letter_ready),
        .flash        (flash),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    function automatic logic [5:0] exp_vec();
        logic [2:0] cnt;
        cnt = 3'(m_q.size());
        return {m_flash, m_busy, (m_q.size() < DEPTH), cnt};
    endfunction

    function automatic bit model_idle();
        return (m_wave.size() == 0) && (m_q.size() == 0) && !m_busy;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_wave.delete();
        m_pop_pending = 1'b0;
        m_flash = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic build(input logic [2:0] l);
        logic [13:0] pat;
        int msb;
        pat = ref_pat[l];
        msb = 0;
        m_wave.push_back(1'b0);
        for (int i = 0; i < 14; i++) if (pat[i]) msb = i;
        for (int i = 0; i <= msb; i++) repeat (TICK_DIV) m_wave.push_back(pat[i]);
        repeat (GAP_TICKS * TICK_DIV) m_wave.push_back(1'b0);
    endtask

    // Drive one cycle of input, advance the model across the edge, settle.
    task automatic step(input logic v, input logic [2:0] l);
        bit accept, start, do_pop, ab;
        letter_valid = v;
        letter_in    = l;
        @(posedge clk);
        ab = 1'b0;
`ifdef MORSE_SEQ_ABORT_EN
        ab = abort;
`endif
        if (ab) begin
            model_clear();
        end else begin
            accept = v && (m_q.size() < DEPTH);
            start  = (m_wave.size() == 0) && (m_q.size() > 0);
            do_pop = m_pop_pending;
            if (start) begin
                build(m_q[0]);
                m_pop_pending = 1'b1;
            end
            if (m_wave.size() > 0) begin
                m_flash = m_wave.pop_front();
                m_busy  = 1'b1;
            end else begin
                m_flash = 1'b0;
                m_busy  = 1'b0;
            end
            if (do_pop) begin
                void'(m_q.pop_front());
                m_pop_pending = 1'b0;
            end
            if (accept) m_q.push_back(l);
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({flash, busy, letter_ready, fifo_count} !== 6'b001000) begin
            n_err++;
            $display("FAIL reset: got %b want %b", {flash, busy, letter_ready, fifo_count}, 6'b001000);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_letter();
        step(1'b1, 3'd0);
        for (int c = 0; c < 200 && !(c > 0 && model_idle()); c++) begin
            n_cmp++;
            if ({flash, busy, letter_ready, fifo_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL single cyc %0d: got %b want %b", c, {flash, busy, letter_ready, fifo_count}, exp_vec());
            end
            step(1'b0, 3'd0);
        end
    endtask

    task automatic test_longest();
        step(1'b1, 3'd7);
        for (int c = 0; c < 200 && !(c > 0 && model_idle()); c++) begin
            n_cmp++;
            if ({flash, busy, letter_ready, fifo_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL longest cyc %0d: got %b want %b", c, {flash, busy, letter_ready, fifo_count}, exp_vec());
            end
            step(1'b0, 3'd0);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 3'd1);
        step(1'b1, 3'd2);
        for (int c = 0; c < 300 && !(c > 0 && model_idle()); c++) begin
            n_cmp++;
            if ({flash, busy, letter_ready, fifo_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL b2b cyc %0d: got %b want %b", c, {flash, busy, letter_ready, fifo_count}, exp_vec());
            end
            step(1'b0, 3'd0);
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, 3'd0);
        for (int c = 0; c < 14; c++) begin
            n_cmp++;
            if ({flash, busy, letter_ready, fifo_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL backpressure cyc %0d: got %b want %b", c, {flash, busy, letter_ready, fifo_count}, exp_vec());
            end
            if (c >= 4 && c < 12) step(1'b1, 3'($urandom_range(0, 7)));
            else step(1'b0, 3'd0);
        end
        for (int c = 0; c < 400 && !model_idle(); c++) begin
            n_cmp++;
            if ({flash, busy, letter_ready, fifo_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL backpressure drain cyc %0d: got %b want %b", c, {flash, busy, letter_ready, fifo_count}, exp_vec());
            end
            step(1'b0, 3'd0);
        end
    endtask

    task automatic test_reset_mid_letter();
        step(1'b1, 3'd6);
        for (int c = 0; c < 12; c++) step(1'b0, 3'd0);
        #3;
        reset_n = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if ({flash, busy, letter_ready, fifo_count} !== 6'b001000) begin
            n_err++;
            $display("FAIL reset_mid async: got %b want %b", {flash, busy, letter_ready, fifo_count}, 6'b001000);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 3'd0);
            n_cmp++;
            if ({flash, busy, letter_ready, fifo_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_mid after cyc %0d: got %b want %b", c, {flash, busy, letter_ready, fifo_count}, exp_vec());
            end
        end
    endtask

`ifdef MORSE_SEQ_ABORT_EN
    task automatic test_abort();
        step(1'b1, 3'd0);
        step(1'b1, 3'd1);
        step(1'b1, 3'd2);
        for (int c = 0; c < 100 && m_wave.size() != 3; c++) step(1'b0, 3'd0);
        abort = 1'b1;
        step(1'b1, 3'd3);
        abort = 1'b0;
        n_cmp++;
        if ({flash, busy, letter_ready, fifo_count} !== 6'b001000) begin
            n_err++;
            $display("FAIL abort: got %b want %b", {flash, busy, letter_ready, fifo_count}, 6'b001000);
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 3'd0);
            n_cmp++;
            if ({flash, busy, letter_ready, fifo_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL abort after cyc %0d: got %b want %b", c, {flash, busy, letter_ready, fifo_count}, exp_vec());
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
            n_cmp++;
            if ({flash, busy, letter_ready, fifo_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b want %b", c, {flash, busy, letter_ready, fifo_count}, exp_vec());
            end
        end
        for (int c = 0; c < 400 && !model_idle(); c++) begin
            step(1'b0, 3'd0);
            n_cmp++;
            if ({flash, busy, letter_ready, fifo_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL random drain cyc %0d: got %b want %b", c, {flash, busy, letter_ready, fifo_count}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_letter();
        test_longest();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_letter();
`ifdef MORSE_SEQ_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
